sd_emmc_adma2_scheduler: RTL and testbench

// - ADMA2 descriptor engine: walks a 32-bit ADMA2 descriptor table in system memory and hands one data segment at a time to the DMA datapath.
// - Sits between the host register block (start/base/abort) and the DMA datapath; owns a private AXI read port for descriptor fetches.

---
 rtl/sd_emmc_adma2_scheduler_pkg.sv | 40 ++++
 rtl/sd_emmc_adma2_scheduler.sv | 270 +++++++++++++++++++++++++++
 tb/tb_sd_emmc_adma2_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_emmc_adma2_scheduler_pkg.sv
// ADMA2 descriptor field positions, Act encodings, error-state codes and scheduler FSM states.
package sd_emmc_adma2_scheduler_pkg;

    localparam int ATTR_VALID_BIT = 0;
    localparam int ATTR_END_BIT   = 1;
    localparam int ATTR_INT_BIT   = 2;
    localparam int ACT_LSB        = 4;
    localparam int LEN_LSB        = 16;

    localparam logic [1:0] ACT_TRAN = 2'b10;
    localparam logic [1:0] ACT_LINK = 2'b11;

    localparam logic [1:0] ST_STOP = 2'b00;
    localparam logic [1:0] ST_FDS  = 2'b01;
    localparam logic [1:0] ST_TFR  = 2'b11;

    localparam int DESC_STRIDE = 8;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH_AR  = 4'd1,
        S_FETCH_R   = 4'd2,
        S_DECODE    = 4'd3,
        S_SEG_ISSUE = 4'd4,
        S_SEG_WAIT  = 4'd5,
        S_DONE      = 4'd6,
        S_ERROR     = 4'd7,
        S_DRAIN     = 4'd8
    } adma_state_e;

    // A zero Length field encodes a full 64 KiB segment.
    function automatic logic [16:0] seg_bytes(input logic [15:0] len_field);
        if (len_field == 16'd0) begin
            seg_bytes = 17'h1_0000;
        end else begin
            seg_bytes = {1'b0, len_field};
        end
    endfunction

endpackage

// File: rtl/sd_emmc_adma2_scheduler.sv
// ADMA2 descriptor walker: fetches 8-byte descriptors over a private AXI read port and offers segments.
// Optional feature macro: SD_ADMA_INT_ATTR_EN (Int attribute drives o_adma_int; otherwise tied 0).
module sd_emmc_adma2_scheduler
    import sd_emmc_adma2_scheduler_pkg::*;
#(
    parameter int LINK_LIMIT = 64,
    parameter int ADDR_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_adma_start,
    input  logic [ADDR_W-1:0] i_adma_desc_base,
    input  logic              i_adma_abort,
    output logic [ADDR_W-1:0] o_desc_araddr,
    output logic              o_desc_arvalid,
    input  logic              i_desc_arready,
    input  logic [31:0]       i_desc_rdata,
    input  logic [1:0]        i_desc_rresp,
    input  logic              i_desc_rvalid,
    input  logic              i_desc_rlast,
    output logic              o_desc_rready,
    output logic [ADDR_W-1:0] o_seg_addr,
    output logic [16:0]       o_seg_len,
    output logic              o_seg_valid,
    input  logic              i_seg_ready,
    input  logic              i_seg_done,
    output logic              o_adma_busy,
    output logic              o_adma_xfer_done,
    output logic              o_adma_int,
    output logic              o_adma_err,
    output logic [1:0]        o_adma_err_state,
    output logic [ADDR_W-1:0] o_adma_err_addr
);

    localparam int                CNT_W    = $clog2(LINK_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LINK_MAX = CNT_W'(LINK_LIMIT);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(DESC_STRIDE);

    adma_state_e       r_state;
    adma_state_e       w_next;
    logic [ADDR_W-1:0] r_desc_ptr;
    logic [CNT_W-1:0]  r_link_cnt;
    logic [CNT_W-1:0]  w_link_inc;
    logic              r_attr_valid;
    logic              r_attr_end;
    logic              r_attr_int;
    logic [1:0]        r_act;
    logic [16:0]       r_len;
    logic [ADDR_W-1:0] r_addr;
    logic              r_beat;
    logic              r_rerr;
    logic              w_rresp_err;
    logic [1:0]        w_err_code;
    logic [ADDR_W-1:0] w_err_addr;
    logic [1:0]        r_err_state;
    logic [ADDR_W-1:0] r_err_addr;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_seg_valid;
    logic              r_busy;
    logic              r_xfer_done;
    logic              r_int;
    logic              r_err;
    logic              w_unused;

    assign w_unused = ^{i_desc_rdata[15:6], i_desc_rdata[3], r_attr_int};

    // Next-state and error classification.
    always_comb begin
        w_next      = r_state;
        w_err_code  = ST_FDS;
        w_err_addr  = r_desc_ptr;
        w_link_inc  = r_link_cnt + CNT_W'(1);
        w_rresp_err = r_rerr | (i_desc_rresp != 2'b00);
        case (r_state)
            S_IDLE: begin
                if (i_adma_abort) begin
                    w_next = S_IDLE;
                end else if (i_adma_start) begin
                    if (i_adma_desc_base[1:0] != 2'b00) begin
                        w_next     = S_ERROR;
                        w_err_addr = i_adma_desc_base;
                    end else begin
                        w_next = S_FETCH_AR;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_FETCH_AR: begin
                // An AR accepted on the abort cycle still owes its R beats.
                if (i_adma_abort) begin
                    w_next = i_desc_arready ? S_DRAIN : S_IDLE;
                end else if (i_desc_arready) begin
                    w_next = S_FETCH_R;
                end else begin
                    w_next = S_FETCH_AR;
                end
            end
            S_FETCH_R: begin
                if (i_adma_abort) begin
                    w_next = (i_desc_rvalid && i_desc_rlast) ? S_IDLE : S_DRAIN;
                end else if (i_desc_rvalid) begin
                    if (!r_beat) begin
                        w_next = i_desc_rlast ? S_ERROR : S_FETCH_R;
                    end else if (w_rresp_err || !i_desc_rlast) begin
                        w_next = S_ERROR;
                    end else begin
                        w_next = S_DECODE;
                    end
                end else begin
                    w_next = S_FETCH_R;
                end
            end
            S_DECODE: begin
                if (i_adma_abort) begin
                    w_next = S_IDLE;
                end else if (!r_attr_valid) begin
                    w_next = S_ERROR;
                end else if (r_act == ACT_TRAN) begin
                    if (r_addr[1:0] != 2'b00) begin
                        w_next     = S_ERROR;
                        w_err_code = ST_TFR;
                    end else begin
                        w_next = S_SEG_ISSUE;
                    end
                end else if ((r_act == ACT_LINK) && (r_addr[1:0] != 2'b00)) begin
                    w_next = S_ERROR;
                end else if ((r_act != ACT_LINK) && r_attr_end) begin
                    w_next = S_DONE;
                end else if (w_link_inc == LINK_MAX) begin
                    w_next = S_ERROR;
                end else begin
                    w_next = S_FETCH_AR;
                end
            end
            S_SEG_ISSUE: begin
                if (i_adma_abort) begin
                    w_next = S_IDLE;
                end else if (i_seg_ready) begin
                    w_next = S_SEG_WAIT;
                end else begin
                    w_next = S_SEG_ISSUE;
                end
            end
            S_SEG_WAIT: begin
                if (i_adma_abort) begin
                    w_next = S_IDLE;
                end else if (i_seg_done) begin
                    w_next = r_attr_end ? S_DONE : S_FETCH_AR;
                end else begin
                    w_next = S_SEG_WAIT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERROR: w_next = S_IDLE;
            S_DRAIN: begin
                if (i_desc_rvalid && i_desc_rlast) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DRAIN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, descriptor datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_desc_ptr   <= '0;
            r_link_cnt   <= '0;
            r_attr_valid <= 1'b0;
            r_attr_end   <= 1'b0;
            r_attr_int   <= 1'b0;
            r_act        <= 2'b00;
            r_len        <= 17'd0;
            r_addr       <= '0;
            r_beat       <= 1'b0;
            r_rerr       <= 1'b0;
            r_err_state  <= ST_STOP;
            r_err_addr   <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_seg_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_xfer_done  <= 1'b0;
            r_int        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_arvalid   <= (w_next == S_FETCH_AR);
            r_rready    <= (w_next == S_FETCH_R) || (w_next == S_DRAIN);
            r_seg_valid <= (w_next == S_SEG_ISSUE);
            r_busy      <= (w_next != S_IDLE);
            r_xfer_done <= (w_next == S_DONE);
            r_err       <= (w_next == S_ERROR);
`ifdef SD_ADMA_INT_ATTR_EN
            r_int       <= (r_state == S_SEG_WAIT) && i_seg_done && !i_adma_abort && r_attr_int;
`else
            r_int       <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (i_adma_start && !i_adma_abort) begin
                        r_desc_ptr  <= i_adma_desc_base;
                        r_link_cnt  <= '0;
                        r_err_state <= ST_STOP;
                        r_err_addr  <= '0;
                    end
                end
                S_FETCH_AR: begin
                    r_beat <= 1'b0;
                    r_rerr <= 1'b0;
                end
                S_FETCH_R: begin
                    if (i_desc_rvalid) begin
                        if (!r_beat) begin
                            r_attr_valid <= i_desc_rdata[ATTR_VALID_BIT];
                            r_attr_end   <= i_desc_rdata[ATTR_END_BIT];
                            r_attr_int   <= i_desc_rdata[ATTR_INT_BIT];
                            r_act        <= i_desc_rdata[ACT_LSB +: 2];
                            r_len        <= seg_bytes(i_desc_rdata[LEN_LSB +: 16]);
                            r_rerr       <= (i_desc_rresp != 2'b00);
                            r_beat       <= 1'b1;
                        end else begin
                            r_addr <= i_desc_rdata[ADDR_W-1:0];
                        end
                    end
                end
                S_DECODE: begin
                    if (w_next == S_FETCH_AR) begin
                        r_link_cnt <= w_link_inc;
                        r_desc_ptr <= (r_act == ACT_LINK) ? r_addr : (r_desc_ptr + STRIDE);
                    end else if (w_next == S_SEG_ISSUE) begin
                        r_link_cnt <= '0;
                    end
                end
                S_SEG_WAIT: begin
                    if (i_seg_done && !i_adma_abort) begin
                        r_desc_ptr <= r_desc_ptr + STRIDE;
                    end
                end
                default: begin
                end
            endcase
            if (w_next == S_ERROR) begin
                r_err_state <= w_err_code;
                r_err_addr  <= w_err_addr;
            end else if (i_adma_abort) begin
                r_err_state <= ST_STOP;
            end
        end
    end

    assign o_desc_araddr    = r_desc_ptr;
    assign o_desc_arvalid   = r_arvalid;
    assign o_desc_rready    = r_rready;
    assign o_seg_addr       = r_addr;
    assign o_seg_len        = r_len;
    assign o_seg_valid      = r_seg_valid;
    assign o_adma_busy      = r_busy;
    assign o_adma_xfer_done = r_xfer_done;
    assign o_adma_int       = r_int;
    assign o_adma_err       = r_err;
    assign o_adma_err_state = r_err_state;
    assign o_adma_err_addr  = r_err_addr;

endmodule

// File: tb/tb_sd_emmc_adma2_scheduler.sv
// Table-driven bench for the ADMA2 scheduler with a small AXI descriptor-memory responder.
module tb_sd_emmc_adma2_scheduler;

`ifdef SD_ADMA_INT_ATTR_EN
    localparam int INT_EN = 1;
`else
    localparam int INT_EN = 0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        i_adma_start, i_adma_abort;
    logic [31:0] i_adma_desc_base;
    logic [31:0] o_desc_araddr;
    logic        o_desc_arvalid, i_desc_arready;
    logic [31:0] i_desc_rdata;
    logic [1:0]  i_desc_rresp;
    logic        i_desc_rvalid, i_desc_rlast, o_desc_rready;
    logic [31:0] o_seg_addr;
    logic [16:0] o_seg_len;
    logic        o_seg_valid, i_seg_ready, i_seg_done;
    logic        o_adma_busy, o_adma_xfer_done, o_adma_int, o_adma_err;
    logic [1:0]  o_adma_err_state;
    logic [31:0] o_adma_err_addr;

    sd_emmc_adma2_scheduler dut (
        .clock(clock), .reset(reset),
        .i_adma_start(i_adma_start), .i_adma_desc_base(i_adma_desc_base), .i_adma_abort(i_adma_abort),
        .o_desc_araddr(o_desc_araddr), .o_desc_arvalid(o_desc_arvalid), .i_desc_arready(i_desc_arready),
        .i_desc_rdata(i_desc_rdata), .i_desc_rresp(i_desc_rresp), .i_desc_rvalid(i_desc_rvalid),
        .i_desc_rlast(i_desc_rlast), .o_desc_rready(o_desc_rready),
        .o_seg_addr(o_seg_addr), .o_seg_len(o_seg_len), .o_seg_valid(o_seg_valid),
        .i_seg_ready(i_seg_ready), .i_seg_done(i_seg_done),
        .o_adma_busy(o_adma_busy), .o_adma_xfer_done(o_adma_xfer_done), .o_adma_int(o_adma_int),
        .o_adma_err(o_adma_err), .o_adma_err_state(o_adma_err_state), .o_adma_err_addr(o_adma_err_addr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] base;
        int          tbl;
        int          exp_segs;
        logic [16:0] exp_len0;
        logic [16:0] exp_len1;
        int          exp_ars;
        logic [31:0] exp_ar_first;
        logic [31:0] exp_ar_last;
        int          exp_done;
        int          exp_int;
        int          exp_err;
        logic [1:0]  exp_st;
        logic [31:0] exp_eaddr;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ar_q [$];
    logic [16:0] seg_len_q [$];
    int          checks = 0, failures = 0;
    int          cnt_done, cnt_int, cnt_err, cnt_both;
    int          cfg_r_delay = 0;
    logic [31:0] cfg_resp_err_addr = 32'hFFFF_FFFF;
    logic [31:0] cfg_early_last_addr = 32'hFFFF_FFFF;
    int          s_phase = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        ar_q.delete();
        seg_len_q.delete();
        cnt_done = 0; cnt_int = 0; cnt_err = 0; cnt_both = 0;
    endtask

    // Descriptor memory images, one per scenario.
    task automatic load_mem(input int tbl);
        mem.delete();
        cfg_r_delay = 0;
        cfg_resp_err_addr = 32'hFFFF_FFFF;
        cfg_early_last_addr = 32'hFFFF_FFFF;
        case (tbl)
            0: begin
                mem[32'h1000] = 32'h0200_0021; mem[32'h1004] = 32'h0000_8000;
                mem[32'h1008] = 32'h0000_0021; mem[32'h100C] = 32'h0000_9000;
                mem[32'h1010] = 32'h0004_0023; mem[32'h1014] = 32'h0000_A000;
            end
            1: begin
                mem[32'h1000] = 32'h0000_0031; mem[32'h1004] = 32'h0000_2000;
                mem[32'h2000] = 32'h0010_0027; mem[32'h2004] = 32'h0000_B000;
            end
            2: begin
                mem[32'h1000] = 32'h0000_0001; mem[32'h1004] = 32'h0000_0000;
            end
            3: begin
                mem[32'h1000] = 32'h0200_0021; mem[32'h1004] = 32'h0000_8002;
            end
            4: begin
                mem[32'h1000] = 32'h0200_0023; mem[32'h1004] = 32'h0000_8000;
                cfg_resp_err_addr = 32'h1000;
            end
            5: begin
                mem[32'h3000] = 32'h0000_0031; mem[32'h3004] = 32'h0000_3000;
            end
            6: begin
                mem[32'h1000] = 32'h0000_0003; mem[32'h1004] = 32'h0000_0000;
            end
            7: begin
                mem[32'h1000] = 32'h0000_0031; mem[32'h1004] = 32'h0000_2001;
            end
            8: begin
                mem[32'h1000] = 32'h0200_0023; mem[32'h1004] = 32'h0000_8000;
                cfg_early_last_addr = 32'h1000;
            end
            default: begin
            end
        endcase
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // AXI descriptor responder: one AR at a time, two beats per burst.
    initial begin
        logic [31:0] s_addr;
        int          s_dly;
        logic        rr_prev;
        s_addr = 32'h0; s_dly = 0; rr_prev = 1'b0;
        i_desc_arready = 1'b0; i_desc_rvalid = 1'b0; i_desc_rlast = 1'b0;
        i_desc_rdata = 32'h0; i_desc_rresp = 2'b00;
        forever begin
            @(posedge clock); #1;
            if (!reset) begin
                s_phase = 0; rr_prev = 1'b0;
                i_desc_arready = 1'b0; i_desc_rvalid = 1'b0; i_desc_rlast = 1'b0;
            end else begin
                case (s_phase)
                    0: if (o_desc_arvalid) begin
                        i_desc_arready = 1'b1;
                        s_addr = o_desc_araddr;
                        ar_q.push_back(o_desc_araddr);
                        s_dly = cfg_r_delay;
                        s_phase = 1;
                    end
                    1: begin
                        i_desc_arready = 1'b0;
                        if (s_dly == 0) begin
                            i_desc_rvalid = 1'b1;
                            i_desc_rdata  = rd_word(s_addr);
                            i_desc_rresp  = 2'b00;
                            i_desc_rlast  = (s_addr == cfg_early_last_addr);
                            s_phase = 2;
                        end else begin
                            s_dly--;
                        end
                    end
                    2: if (rr_prev) begin
                        if (i_desc_rlast) begin
                            i_desc_rvalid = 1'b0; i_desc_rlast = 1'b0;
                            s_phase = 0;
                        end else begin
                            i_desc_rdata = rd_word(s_addr + 32'd4);
                            i_desc_rresp = (s_addr == cfg_resp_err_addr) ? 2'b10 : 2'b00;
                            i_desc_rlast = 1'b1;
                            s_phase = 3;
                        end
                    end
                    3: if (rr_prev) begin
                        i_desc_rvalid = 1'b0; i_desc_rlast = 1'b0; i_desc_rresp = 2'b00;
                        s_phase = 0;
                    end
                    default: s_phase = 0;
                endcase
                rr_prev = o_desc_rready;
            end
        end
    end

    // Pulse monitor.
    initial begin
        forever begin
            @(posedge clock); #1;
            if (reset) begin
                if (o_adma_xfer_done) cnt_done++;
                if (o_adma_int) cnt_int++;
                if (o_adma_err) cnt_err++;
                if (o_adma_int && o_adma_xfer_done) cnt_both++;
            end
        end
    end

    // Start a walk and act as the DMA datapath until the engine goes idle.
    task automatic run_walk(input logic [31:0] base);
        int sph, sdly;
        bit fin;
        clear_logs();
        i_adma_desc_base = base;
        i_adma_start = 1'b1;
        @(negedge clock);
        i_adma_start = 1'b0;
        sph = 0; sdly = 0; fin = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            if (!o_adma_busy) begin
                fin = 1'b1;
            end else begin
                i_seg_done = 1'b0;
                case (sph)
                    0: if (o_seg_valid) begin
                        i_seg_ready = 1'b1;
                        seg_len_q.push_back(o_seg_len);
                        sph = 1;
                    end
                    1: begin i_seg_ready = 1'b0; sdly = 2; sph = 2; end
                    2: if (sdly == 0) begin i_seg_done = 1'b1; sph = 0; end else sdly--;
                    default: sph = 0;
                endcase
                @(negedge clock);
            end
        end
        i_seg_done = 1'b0;
        i_seg_ready = 1'b0;
        chk("walk_terminates", fin, 1);
    endtask

    initial begin
        bit seen;
        reset = 1'b0;
        i_adma_start = 1'b0; i_adma_abort = 1'b0; i_adma_desc_base = 32'h0;
        i_seg_ready = 1'b0; i_seg_done = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_busy", o_adma_busy, 0);
        chk("rst_arvalid", o_desc_arvalid, 0);
        chk("rst_rready", o_desc_rready, 0);
        chk("rst_seg_valid", o_seg_valid, 0);
        chk("rst_seg_len", o_seg_len, 0);
        chk("rst_pulses", {o_adma_xfer_done, o_adma_int, o_adma_err}, 0);
        chk("rst_err_state", o_adma_err_state, 0);
        chk("rst_err_addr", o_adma_err_addr, 0);
        reset = 1'b1;
        @(negedge clock);

        vecs[0] = '{32'h1000, 0, 3, 17'd512, 17'h1_0000, 3, 32'h1000, 32'h1010, 1, 0, 0, 2'b00, 32'h0};
        vecs[1] = '{32'h1000, 1, 1, 17'd16, 17'd0, 2, 32'h1000, 32'h2000, 1, INT_EN, 0, 2'b00, 32'h0};
        vecs[2] = '{32'h1000, 2, 0, 17'd0, 17'd0, 2, 32'h1000, 32'h1008, 0, 0, 1, 2'b01, 32'h1008};
        vecs[3] = '{32'h1000, 3, 0, 17'd0, 17'd0, 1, 32'h1000, 32'h1000, 0, 0, 1, 2'b11, 32'h1000};
        vecs[4] = '{32'h1000, 4, 0, 17'd0, 17'd0, 1, 32'h1000, 32'h1000, 0, 0, 1, 2'b01, 32'h1000};
        vecs[5] = '{32'h3000, 5, 0, 17'd0, 17'd0, 64, 32'h3000, 32'h3000, 0, 0, 1, 2'b01, 32'h3000};
        vecs[6] = '{32'h1002, 0, 0, 17'd0, 17'd0, 0, 32'h0, 32'h0, 0, 0, 1, 2'b01, 32'h1002};
        vecs[7] = '{32'h1000, 6, 0, 17'd0, 17'd0, 1, 32'h1000, 32'h1000, 1, 0, 0, 2'b00, 32'h0};
        vecs[8] = '{32'h1000, 7, 0, 17'd0, 17'd0, 1, 32'h1000, 32'h1000, 0, 0, 1, 2'b01, 32'h1000};
        vecs[9] = '{32'h1000, 8, 0, 17'd0, 17'd0, 1, 32'h1000, 32'h1000, 0, 0, 1, 2'b01, 32'h1000};

        for (int i = 0; i < 10; i++) begin
            load_mem(vecs[i].tbl);
            run_walk(vecs[i].base);
            chk($sformatf("v%0d seg_count", i), seg_len_q.size(), vecs[i].exp_segs);
            if (vecs[i].exp_segs > 0 && seg_len_q.size() > 0)
                chk($sformatf("v%0d seg_len0", i), seg_len_q[0], vecs[i].exp_len0);
            if (vecs[i].exp_segs > 1 && seg_len_q.size() > 1)
                chk($sformatf("v%0d seg_len1", i), seg_len_q[1], vecs[i].exp_len1);
            chk($sformatf("v%0d ar_count", i), ar_q.size(), vecs[i].exp_ars);
            if (vecs[i].exp_ars > 0 && ar_q.size() > 0) begin
                chk($sformatf("v%0d ar_first", i), ar_q[0], vecs[i].exp_ar_first);
                chk($sformatf("v%0d ar_last", i), ar_q[ar_q.size() - 1], vecs[i].exp_ar_last);
            end
            chk($sformatf("v%0d done_pulses", i), cnt_done, vecs[i].exp_done);
            chk($sformatf("v%0d int_pulses", i), cnt_int, vecs[i].exp_int);
            chk($sformatf("v%0d int_with_done", i), cnt_both, vecs[i].exp_int);
            chk($sformatf("v%0d err_pulses", i), cnt_err, vecs[i].exp_err);
            chk($sformatf("v%0d err_state", i), o_adma_err_state, vecs[i].exp_st);
            chk($sformatf("v%0d err_addr", i), o_adma_err_addr, vecs[i].exp_eaddr);
        end
        if (seg_len_q.size() > 0) chk("v9 no_seg", seg_len_q.size(), 0);

        // Abort while the datapath owns a segment; a late seg_done must be ignored.
        load_mem(0);
        clear_logs();
        i_adma_desc_base = 32'h1000;
        i_adma_start = 1'b1;
        @(negedge clock);
        i_adma_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (o_seg_valid) seen = 1'b1; else @(negedge clock);
        end
        chk("abort_sw seg_offered", seen, 1);
        i_seg_ready = 1'b1;
        @(negedge clock);
        i_seg_ready = 1'b0;
        i_adma_abort = 1'b1;
        @(negedge clock);
        i_adma_abort = 1'b0;
        chk("abort_sw busy", o_adma_busy, 0);
        chk("abort_sw err_state", o_adma_err_state, 2'b00);
        i_seg_done = 1'b1;
        @(negedge clock);
        i_seg_done = 1'b0;
        repeat (4) @(negedge clock);
        chk("abort_sw pulses", cnt_done + cnt_int + cnt_err, 0);
        chk("abort_sw stays_idle", o_adma_busy, 0);
        run_walk(32'h1000);
        chk("abort_sw restart segs", seg_len_q.size(), 3);
        chk("abort_sw restart done", cnt_done, 1);

        // Abort with R beats still outstanding: busy holds until the burst drains.
        load_mem(0);
        cfg_r_delay = 4;
        clear_logs();
        i_adma_desc_base = 32'h1000;
        i_adma_start = 1'b1;
        @(negedge clock);
        i_adma_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (s_phase == 1) seen = 1'b1; else @(negedge clock);
        end
        chk("abort_fr ar_issued", seen, 1);
        @(negedge clock);
        i_adma_abort = 1'b1;
        @(negedge clock);
        i_adma_abort = 1'b0;
        chk("abort_fr busy_draining", o_adma_busy, 1);
        chk("abort_fr rready_held", o_desc_rready, 1);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (!o_adma_busy) seen = 1'b1; else @(negedge clock);
        end
        chk("abort_fr drained_idle", seen, 1);
        chk("abort_fr beats_consumed", s_phase, 0);
        chk("abort_fr single_ar", ar_q.size(), 1);
        chk("abort_fr pulses", cnt_done + cnt_int + cnt_err, 0);
        chk("abort_fr err_state", o_adma_err_state, 2'b00);
        cfg_r_delay = 0;
        run_walk(32'h1000);
        chk("abort_fr restart segs", seg_len_q.size(), 3);
        if (seg_len_q.size() == 3) chk("abort_fr restart len2", seg_len_q[2], 17'd4);
        chk("abort_fr restart done", cnt_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
